// File: rtl/seno_pkg.sv
// Shared types and constants for the sine-generator sweep path.
package seno_pkg;

  localparam int SENO_PHASE_W = 32;
  localparam int SENO_DWELL_W = 16;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

  // Sweep settings as held by the register bank
  typedef struct packed {
    logic [SENO_PHASE_W-1:0] start_inc;
    logic [SENO_PHASE_W-1:0] stop_inc;
    logic [SENO_PHASE_W-1:0] step;
    logic [SENO_DWELL_W-1:0] dwell;
    logic                    continuous;
  } sweep_cfg_t;

endpackage

// File: rtl/seno_step_calc.sv
// Next phase increment toward a stop value, clamped so it never passes stop
// or wraps through zero/all-ones. Purely combinational.
module seno_step_calc
  import seno_pkg::*;
#(
  parameter int PHASE_W = SENO_PHASE_W
)(
  input  logic [PHASE_W-1:0] cur,
  input  logic [PHASE_W-1:0] step,
  input  logic [PHASE_W-1:0] stop,
  input  logic               up,
  output logic [PHASE_W-1:0] next
);

  // One extra bit exposes carry-out (up) and borrow (down)
  logic [PHASE_W:0] sum;
  logic [PHASE_W:0] diff;

  assign sum  = {1'b0, cur} + {1'b0, step};
  assign diff = {1'b0, cur} - {1'b0, step};

  // Clamp to stop on overflow/underflow or overshoot; a zero step jumps to stop
  always_comb begin
    next = stop;
    if (step != '0) begin
      if (up) begin
        if (!sum[PHASE_W] && (sum[PHASE_W-1:0] <= stop)) next = sum[PHASE_W-1:0];
      end else begin
        if (!diff[PHASE_W] && (diff[PHASE_W-1:0] >= stop)) next = diff[PHASE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/seno_sweep_ctrl.sv
// Frequency-sweep sequencer: walks the NCO phase increment from start to stop
// in clamped steps, holding each value for a programmed number of sample ticks.
module seno_sweep_ctrl
  import seno_pkg::*;
#(
  parameter int PHASE_W = SENO_PHASE_W,
  parameter int DWELL_W = 16,
  parameter int CNT_W   = 16
)(
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [PHASE_W-1:0] cfg_start_inc,
  input  logic [PHASE_W-1:0] cfg_stop_inc,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_continuous,
  input  logic               start,
  input  logic               abort,
  input  logic               sample_tick,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               phase_inc_load,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sweep_cnt
);

  sweep_state_e state, nxt_state;

  // Shadow copy of the settings, frozen for the duration of a sweep
  logic [PHASE_W-1:0] sh_start, sh_stop, sh_step;
  logic [DWELL_W-1:0] sh_dwell;
  logic               sh_cont, sh_up;

  logic [DWELL_W-1:0] dwell_cnt, nxt_dwell_cnt, dwell_last;
  logic [PHASE_W-1:0] nxt_phase, step_next;
  logic [CNT_W-1:0]   nxt_cnt;
  logic               nxt_load, nxt_done, latch_cfg;

  // A dwell of 0 behaves like 1, so the last tick index is 0 in both cases
  assign dwell_last = (sh_dwell == '0) ? '0 : sh_dwell - 1'b1;

  seno_step_calc #(.PHASE_W(PHASE_W)) u_step (
    .cur  (phase_inc),
    .step (sh_step),
    .stop (sh_stop),
    .up   (sh_up),
    .next (step_next)
  );

  // Next-state and next-output decode; abort overrides everything
  always_comb begin
    nxt_state     = state;
    nxt_phase     = phase_inc;
    nxt_load      = 1'b0;
    nxt_done      = 1'b0;
    nxt_cnt       = sweep_cnt;
    nxt_dwell_cnt = dwell_cnt;
    latch_cfg     = 1'b0;
    if (abort) begin
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            latch_cfg     = 1'b1;
            nxt_phase     = cfg_start_inc;
            nxt_load      = 1'b1;
            nxt_dwell_cnt = '0;
            nxt_cnt       = '0;
            nxt_state     = DWELL;
          end
        end
        DWELL: begin
          if (sample_tick) begin
            if (dwell_cnt == dwell_last) begin
              nxt_dwell_cnt = '0;
              if (phase_inc != sh_stop) begin
                nxt_phase = step_next;
                nxt_load  = 1'b1;
              end else begin
                nxt_cnt = (sweep_cnt == '1) ? sweep_cnt : sweep_cnt + 1'b1;
                if (sh_cont) begin
                  nxt_phase = sh_start;
                  nxt_load  = 1'b1;
                end else begin
                  nxt_state = DONE;
                  nxt_done  = 1'b1;
                end
              end
            end else begin
              nxt_dwell_cnt = dwell_cnt + 1'b1;
            end
          end
        end
        DONE:    nxt_state = IDLE;
        default: nxt_state = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= nxt_state;
  end

  // Registered outputs, counters and shadow settings
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      phase_inc      <= '0;
      phase_inc_load <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sweep_cnt      <= '0;
      dwell_cnt      <= '0;
      sh_start       <= '0;
      sh_stop        <= '0;
      sh_step        <= '0;
      sh_dwell       <= '0;
      sh_cont        <= 1'b0;
      sh_up          <= 1'b0;
    end else begin
      phase_inc      <= nxt_phase;
      phase_inc_load <= nxt_load;
      busy           <= (nxt_state != IDLE);
      done           <= nxt_done;
      sweep_cnt      <= nxt_cnt;
      dwell_cnt      <= nxt_dwell_cnt;
      if (latch_cfg) begin
        sh_start <= cfg_start_inc;
        sh_stop  <= cfg_stop_inc;
        sh_step  <= cfg_step;
        sh_dwell <= cfg_dwell;
        sh_cont  <= cfg_continuous;
        sh_up    <= (cfg_start_inc <= cfg_stop_inc);
      end
    end
  end

endmodule
